// File: rtl/btb_table_if.sv
// Lookup/update bundle between fetch, branch resolution and the BTB storage.
// master = fetch/execute side, slave = btb_table.
interface btb_table_if;
   logic        rdEn;
   logic [31:0] rdPC;
   logic        predValid;
   logic [33:0] predOut;
   logic        wrEn;
   logic [31:0] wrPC;
   logic [31:0] wrTarget;
   logic        wrTaken;
   logic        busy;

   modport master (
      output rdEn, rdPC, wrEn, wrPC, wrTarget, wrTaken,
      input  predValid, predOut, busy
   );

   modport slave (
      input  rdEn, rdPC, wrEn, wrPC, wrTarget, wrTaken,
      output predValid, predOut, busy
   );
endinterface

// File: rtl/btb_table.sv
// Branch target buffer: valid flops + tag/content array, clear sweep after reset.
// Optional BTB_WRITE_BYPASS_EN forwards a same-edge, same-index write to the read.
//
// state | meaning
// CLEAR | sweep clears one valid bit per cycle, busy=1, lookups miss, updates dropped
// RUN   | normal lookup/update operation, busy=0
module btb_table #(
   parameter int ENTRY_NUM     = 1024,
   parameter int TAG_WIDTH     = 4,
   parameter int CONTENT_WIDTH = 13
) (
   input  logic      clk,
   input  logic      rst,
   btb_table_if.slave bus
);
   localparam int IW = $clog2(ENTRY_NUM);
   localparam int DW = TAG_WIDTH + CONTENT_WIDTH;

   typedef enum logic {CLEAR, RUN} state_t;

   state_t                 state, state_nx;
   logic [IW-1:0]          cnt;
   logic                   busy_w;
   logic [ENTRY_NUM-1:0]   valid;
   logic [DW-1:0]          mem [ENTRY_NUM];

   logic [IW-1:0]          rd_idx, wr_idx;
   logic [TAG_WIDTH-1:0]   wr_tag;
   logic [CONTENT_WIDTH-1:0] wr_content;
   logic                   wr_act;

   logic                   req_q, run_q, vld_q;
   logic [31:0]            pc_q;
   logic [DW-1:0]          ent_q;
   logic                   hit;
   logic                   unused_ok;

   assign rd_idx     = bus.rdPC[IW+1:2];
   assign wr_idx     = bus.wrPC[IW+1:2];
   assign wr_tag     = bus.wrPC[IW+TAG_WIDTH+1:IW+2];
   assign wr_content = bus.wrTarget[CONTENT_WIDTH+1:2];
   assign wr_act     = bus.wrEn && (state == RUN);
   assign unused_ok  = ^{bus.wrPC[31:IW+TAG_WIDTH+2], bus.wrPC[1:0],
                         bus.wrTarget[31:CONTENT_WIDTH+2], bus.wrTarget[1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (state == CLEAR) cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      busy_w   = 1'b0;
      case (state)
         CLEAR: begin
            busy_w = 1'b1;
            if (cnt == IW'(ENTRY_NUM - 1)) state_nx = RUN;
         end
         RUN: ;
         default: state_nx = CLEAR;
      endcase
   end

   assign bus.busy = busy_w;

   // Valid bits carry no reset; the sweep is what makes them trustworthy.
   always_ff @(posedge clk) begin
      if (state == CLEAR)
         valid[cnt] <= 1'b0;
      else if (wr_act)
         valid[wr_idx] <= bus.wrTaken;
   end

   always_ff @(posedge clk) begin
      if (wr_act && bus.wrTaken) mem[wr_idx] <= {wr_tag, wr_content};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q <= 1'b0;
         run_q <= 1'b0;
      end else begin
         req_q <= bus.rdEn;
         run_q <= (state == RUN);
      end
   end

   always_ff @(posedge clk) begin
      if (bus.rdEn) begin
         pc_q  <= bus.rdPC;
         ent_q <= mem[rd_idx];
         vld_q <= valid[rd_idx];
`ifdef BTB_WRITE_BYPASS_EN
         if (wr_act && (wr_idx == rd_idx)) begin
            ent_q <= {wr_tag, wr_content};
            vld_q <= bus.wrTaken;
         end
`endif
      end
   end

   assign hit = run_q && vld_q && (ent_q[DW-1:CONTENT_WIDTH] == pc_q[IW+TAG_WIDTH+1:IW+2]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.predValid <= 1'b0;
         bus.predOut   <= '0;
      end else begin
         bus.predValid <= req_q;
         if (req_q) begin
            if (hit)
               bus.predOut <= {2'b11, pc_q[31:CONTENT_WIDTH+2], ent_q[CONTENT_WIDTH-1:0], 2'b00};
            else
               bus.predOut <= {2'b00, pc_q + 32'd4};
         end
      end
   end
endmodule

// File: tb/tb_btb_table.sv
// Randomized + directed bench for btb_table with a queue scoreboard and an
// associative-array reference model of the BTB contents.
module tb_btb_table;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   btb_table_if bif();
   btb_table dut (.clk(clk), .rst(rst), .bus(bif));

   int checks = 0;
   int passes = 0;
   int edges  = 0;
   logic [33:0] expq[$];

   bit          mv[int];
   logic [31:0] mpc[int];
   logic [31:0] mtgt[int];

   task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [33:0] model_read(input logic [31:0] pc, input bit sweeping);
      int idx, tag;
      idx = int'((pc >> 2) % 1024);
      tag = int'((pc >> 12) % 16);
      if (!sweeping && mv.exists(idx) && mv[idx] && int'((mpc[idx] >> 12) % 16) == tag)
         return {2'b11, (pc & 32'hFFFF_8000) | (mtgt[idx] & 32'h0000_7FFC)};
      return {2'b00, pc + 32'd4};
   endfunction

   task automatic model_write(input logic [31:0] pc, input logic [31:0] tgt, input bit tk,
                              input bit sweeping);
      int idx;
      if (sweeping) return;
      idx = int'((pc >> 2) % 1024);
      mv[idx] = tk;
      if (tk) begin
         mpc[idx]  = pc;
         mtgt[idx] = tgt;
      end
   endtask

   task automatic step(input bit rd, input logic [31:0] rpc, input bit wr,
                       input logic [31:0] wpc, input logic [31:0] wtgt, input bit wtk);
      bit sw;
      bif.rdEn = rd; bif.rdPC = rpc;
      bif.wrEn = wr; bif.wrPC = wpc; bif.wrTarget = wtgt; bif.wrTaken = wtk;
      sw = (edges < 1024);
`ifdef BTB_WRITE_BYPASS_EN
      if (wr) model_write(wpc, wtgt, wtk, sw);
      if (rd) expq.push_back(model_read(rpc, sw));
`else
      if (rd) expq.push_back(model_read(rpc, sw));
      if (wr) model_write(wpc, wtgt, wtk, sw);
`endif
      @(posedge clk);
      edges++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 32'h0, 0, 32'h0, 32'h0, 0);
   endtask

   // Runs the clear sweep; lookup at step 10 must miss, write at step 20 must be dropped.
   task automatic sweep(input int stop_at, input string name);
      int n = 0;
      bit done = 0;
      while (!done) begin
         if (n == 10)      step(1, 32'h0000_1000, 0, 32'h0, 32'h0, 0);
         else if (n == 20) step(0, 32'h0, 1, 32'h0000_1000, 32'h0000_2468, 1);
         else              step(0, 32'h0, 0, 32'h0, 32'h0, 0);
         n++;
         if (stop_at != 0 && n == stop_at) return;
         if (bif.busy !== 1'b1 || n > 2000) done = 1;
      end
      chk(name, 34'(n), 34'd1024);
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0 && bif.predValid === 1'b1) begin
         if (expq.size() == 0) begin
            checks++;
            $display("FAIL unexpected_pred: got %h expected no output", bif.predOut);
         end else begin
            chk("pred", bif.predOut, expq.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit rd, wr, tk;
      logic [31:0] rpc, wpc, tgt;

      rst = 1'b1;
      bif.rdEn = 0; bif.rdPC = '0; bif.wrEn = 0; bif.wrPC = '0; bif.wrTarget = '0; bif.wrTaken = 0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 34'(bif.busy), 34'd1);
      chk("rst_predValid", 34'(bif.predValid), 34'd0);
      chk("rst_predOut", bif.predOut, 34'd0);
      rst = 1'b0;
      edges = 0;
      sweep(0, "sweep_len");

      step(1, 32'h0000_1000, 0, 32'h0, 32'h0, 0);
      step(0, 32'h0, 1, 32'h0000_1000, 32'h0000_2468, 1);
      step(1, 32'h0000_1000, 0, 32'h0, 32'h0, 0);
      step(1, 32'h0001_1000, 0, 32'h0, 32'h0, 0);
      step(1, 32'h0000_2000, 0, 32'h0, 32'h0, 0);
      step(1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0);
      step(0, 32'h0, 1, 32'h0000_1000, 32'h0, 0);
      step(1, 32'h0000_1000, 0, 32'h0, 32'h0, 0);
      step(1, 32'h0000_1000, 1, 32'h0000_1000, 32'h0000_2468, 1);
      step(1, 32'h0000_1000, 0, 32'h0, 32'h0, 0);
      step(1, 32'h0000_1004, 1, 32'h0000_1008, 32'h0000_5550, 1);
      step(1, 32'h0000_1008, 0, 32'h0, 32'h0, 0);
      idle(3);

      for (int i = 0; i < 3000; i++) begin
         rd  = ($urandom_range(0, 9) < 7);
         wr  = ($urandom_range(0, 9) < 4);
         tk  = ($urandom_range(0, 9) < 7);
         rpc = ($urandom << 16) | (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 7)) << 2);
         wpc = ($urandom << 16) | (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 7)) << 2);
         tgt = $urandom & 32'hFFFF_FFFC;
         step(rd, rpc, wr, wpc, tgt, tk);
      end
      idle(3);

      step(0, 32'h0, 1, 32'h0000_3000, 32'h0000_4444, 1);
      step(1, 32'h0000_3000, 0, 32'h0, 32'h0, 0);
      step(1, 32'h0000_3000, 0, 32'h0, 32'h0, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("run_rst_busy", 34'(bif.busy), 34'd1);
      chk("run_rst_predValid", 34'(bif.predValid), 34'd0);
      chk("run_rst_predOut", bif.predOut, 34'd0);
      expq.delete();
      mv.delete();
      @(negedge clk);
      #1 rst = 1'b0;
      edges = 0;
      sweep(500, "");
      #2;
      rst = 1'b1;
      #1;
      chk("sweep_rst_busy", 34'(bif.busy), 34'd1);
      chk("sweep_rst_predValid", 34'(bif.predValid), 34'd0);
      @(negedge clk);
      #1 rst = 1'b0;
      edges = 0;
      sweep(0, "sweep_len_after_rst");
      step(1, 32'h0000_3000, 0, 32'h0, 32'h0, 0);
      idle(3);

      chk("queue_drained", 34'(expq.size()), 34'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
